// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: opcodes, status codes, D-register record and fetch FSM states.
// Constants only. No timing and no flow control.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_FROZEN = 1'b1
  } fetch_state_t;

  // valP is kept outside the record because its width follows ADDR_W.
  typedef struct packed {
    stat_t       stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
  } d_rec_t;

  localparam d_rec_t D_BUBBLE = '{
    stat:  STAT_BUB,
    icode: INOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  64'h0
  };

endpackage

// File: rtl/y86_instr_split.sv
// Splits a 10-byte fetch window into instruction fields, length, valP and fetch status.
// Purely combinational. No flow control.
module y86_instr_split
  import y86_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int IMEM_BYTES = 4096
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [79:0]       data,
  input  logic              mem_err,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        ra,
  output logic [3:0]        rb,
  output logic [63:0]       valc,
  output logic [ADDR_W-1:0] valp,
  output stat_t             stat
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(IMEM_BYTES);

  logic          need_regids;
  logic          need_valc;
  logic          ifun_ok;
  logic          valid;
  logic [3:0]    len;
  logic [ADDR_W:0] last_byte;

  assign icode = data[7:4];
  assign ifun  = data[3:0];

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (icode)
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids = 1'b1;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      IJXX, ICALL: need_valc = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ifun_ok = 1'b0;
    case (icode)
      IRRMOVQ, IJXX: ifun_ok = (ifun <= 4'd6);
      IOPQ:          ifun_ok = (ifun <= 4'd3);
      default:       ifun_ok = (ifun == 4'd0);
    endcase
  end

  assign valid = (icode <= IPOPQ) && ifun_ok;

  assign ra   = need_regids ? data[15:12] : RNONE;
  assign rb   = need_regids ? data[11:8]  : RNONE;
  assign valc = !need_valc  ? 64'h0 : (need_regids ? data[79:16] : data[71:8]);

  assign len  = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
  assign valp = pc + ADDR_W'(len);

  // One extra bit so a window near the top of the address space cannot wrap past the limit check.
  assign last_byte = {1'b0, pc} + (ADDR_W+1)'(len) - (ADDR_W+1)'(1);

  always_comb begin
    stat = STAT_AOK;
    if (mem_err || (last_byte >= MEM_LIMIT)) stat = STAT_ADR;
    else if (!valid)                         stat = STAT_INS;
    else if (icode == IHALT)                 stat = STAT_HLT;
  end

endmodule

// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: PC select, next-PC prediction, fetch-freeze FSM, F and D registers.
// One edge from selected fetch PC to D_*; F_stall/D_stall hold, D_bubble inserts a nop.
module y86_fetch_stage
  import y86_pkg::*;
#(
  parameter int              ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              IMEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [79:0]       imem_data,
  input  logic              imem_err,
  input  logic [3:0]        M_icode,
  input  logic              M_cnd,
  input  logic [63:0]       M_valA,
  input  logic [3:0]        W_icode,
  input  logic [63:0]       W_valM,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  output logic [2:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [63:0]       D_valC,
  output logic [ADDR_W-1:0] D_valP,
  output logic              fetch_frozen
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pred_pc;
  logic [ADDR_W-1:0] f_pc;
  logic [ADDR_W-1:0] pred_nxt;
  logic              mispredict;
  logic              ret_redirect;
  logic              redirect;
  logic              hold_fetch;
  logic              load_d;

  d_rec_t            f_rec;
  logic [ADDR_W-1:0] f_valp;
  d_rec_t            d_rec;
  logic [ADDR_W-1:0] d_valp;

  assign mispredict   = (M_icode == IJXX) && !M_cnd;
  assign ret_redirect = (W_icode == IRET);
  assign redirect     = mispredict || ret_redirect;

  always_comb begin
    f_pc = pred_pc;
    if (mispredict)        f_pc = M_valA[ADDR_W-1:0];
    else if (ret_redirect) f_pc = W_valM[ADDR_W-1:0];
  end

  assign imem_addr = f_pc;

  y86_instr_split #(
    .ADDR_W     (ADDR_W),
    .IMEM_BYTES (IMEM_BYTES)
  ) u_split (
    .pc      (f_pc),
    .data    (imem_data),
    .mem_err (imem_err),
    .icode   (f_rec.icode),
    .ifun    (f_rec.ifun),
    .ra      (f_rec.ra),
    .rb      (f_rec.rb),
    .valc    (f_rec.valc),
    .valp    (f_valp),
    .stat    (f_rec.stat)
  );

  assign pred_nxt = ((f_rec.icode == IJXX) || (f_rec.icode == ICALL)) ? f_rec.valc[ADDR_W-1:0] : f_valp;

  // While frozen, only an older instruction's redirect may restart fetch.
  assign hold_fetch = (state == FS_FROZEN) && !redirect;
  assign load_d     = !D_stall && !D_bubble && !hold_fetch;

  always_comb begin
    state_nxt = state;
    if (load_d && (f_rec.stat != STAT_AOK))        state_nxt = FS_FROZEN;
    else if ((state == FS_FROZEN) && redirect)     state_nxt = FS_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FS_RUN;
      pred_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (!F_stall && !hold_fetch) pred_pc <= pred_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_rec  <= D_BUBBLE;
      d_valp <= '0;
    end else if (D_stall) begin
      d_rec  <= d_rec;
      d_valp <= d_valp;
    end else if (D_bubble || hold_fetch) begin
      d_rec  <= D_BUBBLE;
      d_valp <= '0;
    end else begin
      d_rec  <= f_rec;
      d_valp <= f_valp;
    end
  end

  assign D_stat       = d_rec.stat;
  assign D_icode      = d_rec.icode;
  assign D_ifun       = d_rec.ifun;
  assign D_rA         = d_rec.ra;
  assign D_rB         = d_rec.rb;
  assign D_valC       = d_rec.valc;
  assign D_valP       = d_valp;
  assign fetch_frozen = (state == FS_FROZEN);

endmodule

// File: tb/tb_y86_fetch_stage.sv
// Scoreboard bench for y86_fetch_stage: a 64-bit/4 KiB instance running a small program and a
// 16-bit/16-byte instance covering address errors and valP wrap.
module tb_y86_fetch_stage;

  logic clk;
  logic rst_n;

  // main instance (ADDR_W=64, IMEM_BYTES=4096)
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic        imem_err;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic        F_stall, D_stall, D_bubble;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;
  logic        fetch_frozen;

  // narrow instance (ADDR_W=16, IMEM_BYTES=16, RESET_PC=8)
  logic [15:0] imem_addr2;
  logic [79:0] imem_data2;
  logic [3:0]  W2_icode;
  logic [63:0] W2_valM;
  logic [3:0]  M2_icode;
  logic [2:0]  D2_stat;
  logic [3:0]  D2_icode, D2_ifun, D2_rA, D2_rB;
  logic [63:0] D2_valC;
  logic [15:0] D2_valP;
  logic        fetch_frozen2;

  logic [7:0] mem [0:4095];

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    int          dut;
    logic [63:0] a;
  } aexp_t;

  typedef struct {
    int          cyc;
    int          dut;
    logic [2:0]  st;
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] vc;
    logic [63:0] vp;
    logic        fr;
  } dexp_t;

  aexp_t aq[$];
  dexp_t dq[$];

  localparam logic [2:0] BUB = 3'd0, AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

  y86_fetch_stage #(
    .ADDR_W     (64),
    .RESET_PC   (64'h0),
    .IMEM_BYTES (4096)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_err     (imem_err),
    .M_icode      (M_icode),
    .M_cnd        (M_cnd),
    .M_valA       (M_valA),
    .W_icode      (W_icode),
    .W_valM       (W_valM),
    .F_stall      (F_stall),
    .D_stall      (D_stall),
    .D_bubble     (D_bubble),
    .D_stat       (D_stat),
    .D_icode      (D_icode),
    .D_ifun       (D_ifun),
    .D_rA         (D_rA),
    .D_rB         (D_rB),
    .D_valC       (D_valC),
    .D_valP       (D_valP),
    .fetch_frozen (fetch_frozen)
  );

  y86_fetch_stage #(
    .ADDR_W     (16),
    .RESET_PC   (16'h0008),
    .IMEM_BYTES (16)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr2),
    .imem_data    (imem_data2),
    .imem_err     (1'b0),
    .M_icode      (M2_icode),
    .M_cnd        (1'b1),
    .M_valA       (64'h0),
    .W_icode      (W2_icode),
    .W_valM       (W2_valM),
    .F_stall      (1'b0),
    .D_stall      (1'b0),
    .D_bubble     (1'b0),
    .D_stat       (D2_stat),
    .D_icode      (D2_icode),
    .D_ifun       (D2_ifun),
    .D_rA         (D2_rA),
    .D_rB         (D2_rB),
    .D_valC       (D2_valC),
    .D_valP       (D2_valP),
    .fetch_frozen (fetch_frozen2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    imem_data = '0;
    for (int i = 0; i < 10; i++) imem_data[8*i +: 8] = mem[12'(imem_addr + 64'(i))];
  end

  always_comb begin
    case (imem_addr2)
      16'h0008: imem_data2 = 80'h0A_F3_30;   // irmovq $10,%rbx
      16'hFFFF: imem_data2 = 80'h10;         // nop
      default:  imem_data2 = '0;
    endcase
  end

  task automatic chk(input string nm, input int dutn, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", nm, dutn, cyc, act, exp);
    end
  endtask

  // Monitor: compares every expectation whose target cycle has arrived.
  always @(negedge clk) begin
    aexp_t ae;
    dexp_t de;
    while (aq.size() > 0 && aq[0].cyc <= cyc) begin
      ae = aq.pop_front();
      if (ae.cyc < cyc) chk("stale_addr_expectation", ae.dut, 64'(ae.cyc), 64'(cyc));
      else chk("imem_addr", ae.dut, ae.dut != 0 ? 64'(imem_addr2) : imem_addr, ae.a);
    end
    while (dq.size() > 0 && dq[0].cyc <= cyc) begin
      de = dq.pop_front();
      if (de.cyc < cyc) chk("stale_d_expectation", de.dut, 64'(de.cyc), 64'(cyc));
      else if (de.dut != 0) begin
        chk("D_stat",       1, 64'(D2_stat),       64'(de.st));
        chk("D_icode",      1, 64'(D2_icode),      64'(de.ic));
        chk("D_ifun",       1, 64'(D2_ifun),       64'(de.fn));
        chk("D_rA",         1, 64'(D2_rA),         64'(de.ra));
        chk("D_rB",         1, 64'(D2_rB),         64'(de.rb));
        chk("D_valC",       1, D2_valC,            de.vc);
        chk("D_valP",       1, 64'(D2_valP),       de.vp);
        chk("fetch_frozen", 1, 64'(fetch_frozen2), 64'(de.fr));
      end else begin
        chk("D_stat",       0, 64'(D_stat),       64'(de.st));
        chk("D_icode",      0, 64'(D_icode),      64'(de.ic));
        chk("D_ifun",       0, 64'(D_ifun),       64'(de.fn));
        chk("D_rA",         0, 64'(D_rA),         64'(de.ra));
        chk("D_rB",         0, 64'(D_rB),         64'(de.rb));
        chk("D_valC",       0, D_valC,            de.vc);
        chk("D_valP",       0, D_valP,            de.vp);
        chk("fetch_frozen", 0, 64'(fetch_frozen), 64'(de.fr));
      end
    end
  end

  task automatic set_defaults();
    rst_n    = 1'b1;
    imem_err = 1'b0;
    M_icode  = 4'h1;
    M_cnd    = 1'b1;
    M_valA   = 64'h0;
    W_icode  = 4'h1;
    W_valM   = 64'h0;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    W2_icode = 4'h1;
    W2_valM  = 64'h0;
    M2_icode = 4'h1;
  endtask

  // Expectation for the narrow instance in the current cycle (no clock edge).
  task automatic push2(input bit ca, input logic [63:0] a, input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp, input logic fr);
    if (ca) aq.push_back('{cyc, 1, a});
    dq.push_back('{cyc + 1, 1, st, ic, fn, ra, rb, vc, vp, fr});
  endtask

  // Expectation for the main instance: imem_addr this cycle, D_* after the coming edge.
  task automatic step(input bit ca, input logic [63:0] a, input logic [2:0] st, input logic [3:0] ic,
                      input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] vc, input logic [63:0] vp, input logic fr);
    if (ca) aq.push_back('{cyc, 0, a});
    dq.push_back('{cyc + 1, 0, st, ic, fn, ra, rb, vc, vp, fr});
    @(posedge clk);
    #1;
    set_defaults();
  endtask

  task automatic step_bub(input bit ca, input logic [63:0] a, input logic fr);
    step(ca, a, BUB, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, fr);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem['h00] = 8'h30; mem['h01] = 8'hF3; mem['h02] = 8'h0A;   // irmovq $10,%rbx
    mem['h0A] = 8'h70; mem['h0B] = 8'h60;                      // jmp 0x60
    mem['h60] = 8'h74; mem['h61] = 8'h40;                      // jne 0x40
    mem['h40] = 8'h10;                                         // nop (predicted path)
    mem['h69] = 8'h20; mem['h6A] = 8'h12;                      // rrmovq %rcx,%rdx
    mem['h6B] = 8'h70; mem['h6C] = 8'h20;                      // jmp 0x20
    mem['h30] = 8'h60; mem['h31] = 8'h01;                      // addq %rax,%rcx
    mem['h32] = 8'h2F; mem['h33] = 8'h00;                      // bad ifun
    mem['h50] = 8'h10; mem['h51] = 8'h10; mem['h52] = 8'h10; mem['h53] = 8'h10;
    mem['h54] = 8'hC0;                                         // bad icode

    set_defaults();
    rst_n = 1'b0;

    push2(0, 0, BUB, 4'h1, 4'h0, 4'hF, 4'hF, 0, 0, 0);
    step_bub(0, 0, 0);                                             // reset
    push2(1, 64'h8, ADR, 4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 64'h12, 1);
    step(1, 64'h00, AOK, 4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 64'hA, 0);   // irmovq
    push2(1, 64'h12, BUB, 4'h1, 4'h0, 4'hF, 4'hF, 0, 0, 1);
    step(1, 64'h0A, AOK, 4'h7, 4'h0, 4'hF, 4'hF, 64'h60, 64'h13, 0); // jmp
    W2_icode = 4'h9; W2_valM = 64'hFFFF;
    push2(1, 64'hFFFF, ADR, 4'h1, 4'h0, 4'hF, 4'hF, 0, 0, 1);
    step(1, 64'h60, AOK, 4'h7, 4'h4, 4'hF, 4'hF, 64'h40, 64'h69, 0); // jne
    push2(1, 64'h0, BUB, 4'h1, 4'h0, 4'hF, 4'hF, 0, 0, 1);
    step(1, 64'h40, AOK, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h41, 0);      // predicted nop
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h69;
    step(1, 64'h69, AOK, 4'h2, 4'h0, 4'h1, 4'h2, 0, 64'h6B, 0);      // mispredict
    step(1, 64'h6B, AOK, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h74, 0);
    step(1, 64'h20, HLT, 4'h0, 4'h0, 4'hF, 4'hF, 0, 64'h21, 1);      // halt
    for (int i = 0; i < 3; i++) step_bub(1, 64'h21, 1);
    W_icode = 4'h9; W_valM = 64'h30;
    step(1, 64'h30, AOK, 4'h6, 4'h0, 4'h0, 4'h1, 0, 64'h32, 0);      // ret redirect
    step(1, 64'h32, INS, 4'h2, 4'hF, 4'h0, 4'h0, 0, 64'h34, 1);      // invalid ifun
    step_bub(1, 64'h34, 1);
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h50;
    step(1, 64'h50, AOK, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h51, 0);
    for (int i = 0; i < 2; i++) begin
      F_stall = 1'b1; D_stall = 1'b1;
      step(1, 64'h51, AOK, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h51, 0);
    end
    step(1, 64'h51, AOK, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h52, 0);
    D_bubble = 1'b1;
    step_bub(1, 64'h52, 0);
    step(1, 64'h53, AOK, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h54, 0);
    F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1;
    step(1, 64'h53 + 64'h1, AOK, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h54, 0); // stall beats bubble
    imem_err = 1'b1;
    step(1, 64'h54, ADR, 4'hC, 4'h0, 4'hF, 4'hF, 0, 64'h55, 1);      // ADR beats INS
    step_bub(1, 64'h55, 1);
    rst_n = 1'b0; D_stall = 1'b1;
    push2(0, 0, BUB, 4'h1, 4'h0, 4'hF, 4'hF, 0, 0, 0);
    step_bub(1, 64'h55, 0);                                          // reset while frozen
    push2(1, 64'h8, ADR, 4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 64'h12, 1);
    step(1, 64'h00, AOK, 4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 64'hA, 0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, 64'(aq.size() + dq.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end of stimulus");
    $fatal(1);
  end

endmodule

// File: doc/y86_fetch_stage.md
Name: y86_fetch_stage

Overview:
- Parametrised pipelined fetch stage for the Y86-64 core. Replaces the combinational fetch decode.
- Owns the F register (predicted PC) and the D pipeline register. Selects the fetch PC from the prediction, a mispredicted-branch redirect or a ret redirect.
- Reads a 10-byte window from an external instruction memory port and splits the instruction.
- Adds a fetch-freeze state machine: fetching stops after a halt, invalid or error instruction until an older instruction redirects it.

Parameters:
ADDR_W, 64, PC/address width in bits (valC stays 64 bits; PC values are truncated/zero-extended to ADDR_W).
RESET_PC, 0, value loaded into predPC on reset.
IMEM_BYTES, 4096, memory size; a fetch window extending past IMEM_BYTES-1 raises an address error.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
imem_addr  out  ADDR_W  selected fetch PC (f_pc)
imem_data  in  80  bytes pc..pc+9, byte 0 in bits [7:0]
imem_err  in  1  memory-side error for this window
M_icode  in  4  icode in Memory stage
M_cnd  in  1  branch condition in Memory stage
M_valA  in  64  fall-through PC of jXX in Memory stage
W_icode  in  4  icode in Writeback stage
W_valM  in  64  return address in Writeback stage
F_stall  in  1  hold F register
D_stall  in  1  hold D register
D_bubble  in  1  load nop bubble into D
D_stat  out  3  status: AOK=1, HLT=2, ADR=3, INS=4, BUB=0
D_icode, D_ifun  out  4 each  opcode fields
D_rA, D_rB  out  4 each  register ids (0xF = none)
D_valC  out  64  constant word
D_valP  out  ADDR_W  next sequential PC
fetch_frozen  out  1  high while the FSM is in FROZEN

Behaviour:
- Fetch PC select (combinational), first match wins:
  - M_icode==7 && !M_cnd -> M_valA
  - W_icode==9 -> W_valM
  - else predPC
- Split: icode=byte0[7:4], ifun=byte0[3:0].
  - need_regids for icode in {2,3,4,5,6,A,B}.
  - need_valC for icode in {3,4,5,7,8}.
  - valC = bytes 2..9 if need_regids, else bytes 1..8; little-endian; 0 if not needed.
  - rA/rB = byte1 nibbles [7:4]/[3:0] if need_regids, else 0xF.
- valP = pc + 1 + need_regids + 8*need_valC, modulo 2^ADDR_W.
- Valid instruction:
  - icode<=B.
  - ifun<=6 for icode 2 and 7; ifun<=3 for icode 6; ifun==0 otherwise.
- Status, by priority:
  - imem_err, or pc+len-1 >= IMEM_BYTES -> ADR
  - invalid instruction -> INS
  - icode==0 -> HLT
  - else AOK
- Predicted PC: valC for icode 7 or 8, else valP.
- FSM states are RUN and FROZEN.
  - RUN -> FROZEN when a non-AOK instruction is loaded into D (not stalled, not bubbled).
  - FROZEN -> RUN when a mispredict or ret redirect is active; that redirected fetch is loaded normally in the same cycle.
  - In FROZEN without a redirect: predPC holds, and D loads a bubble unless D_stall is high.
- F register update:
  - predPC <= predicted PC unless F_stall, or FROZEN without a redirect.
  - A redirect overrides F_stall only when F_stall is low.
  - F_stall has priority over a redirect.
- D register update, priority: reset, then D_stall (hold), then D_bubble, then fetched values.
  - Bubble / reset value: stat=BUB(0), icode=1 (nop), ifun=0, rA=rB=0xF, valC=0, valP=0.
  - D_stall && D_bubble together: stall wins.
- Reset, including mid-operation: predPC=RESET_PC, FSM=RUN, D = bubble, fetch_frozen=0. Takes effect at the next edge regardless of the stall and bubble inputs.
- Latency: instruction at f_pc appears on D_* one edge after selection.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (IHALT=0 ... IPOPQ=B)
  - stat codes (BUB, AOK, HLT, ADR, INS)
  - RNONE=0xF
  - the bubble record
  - FSM state enum
- One natural sub-module, y86_instr_split: purely combinational split, need flags, valid check, length and valP. Fetch stage instantiates it and adds select, predict, FSM and registers.

Test Plan:
- Reset then bytes 30 F3 0A 00..00 at PC 0 (irmovq $10,%rbx) -> after 1 edge D_icode=3, rA=F, rB=3, valC=0xA, valP=0xA, stat=AOK; next imem_addr=0xA.
- jXX at 0x10: bytes 70 40 00.. -> predPC=0x40; later M_icode=7, M_cnd=0, M_valA=0x19 -> imem_addr=0x19 same cycle, D gets the fall-through instruction.
- Bytes 00 at 0x20 -> D_stat=HLT, fetch_frozen=1. The next 3 edges hold predPC and give bubbles in D. Then W_icode=9, W_valM=0x30 -> imem_addr=0x30, RUN.
- Byte 2F at PC 0 -> D_stat=INS, frozen. With IMEM_BYTES=16, a 10-byte instr at PC 8 -> ADR. With imem_err=1 -> ADR (ADR beats INS).
- F_stall=1 and D_stall=1 for 2 cycles -> outputs and imem_addr unchanged. D_bubble=1 alone -> D_icode=1, stat=BUB. D_stall and D_bubble together -> hold.
- Assert rst_n=0 while FROZEN with D_stall=1 -> next edge predPC=RESET_PC, D bubble, fetch_frozen=0.
- ADDR_W=16: PC 0xFFFF with a 1-byte nop -> D_valP=0x0000 (wrap).
